step_axis_driver: RTL and testbench

- Actuator end of the axis sweep interface: consumes the 2-bit step commands issued by the sweep controller.
- Drives the stepper coil phases and tracks absolute position.
- Returns the mn/mx limit flags that the controller uses to reverse direction.
- Sits between the controller FSM and the motor pins; also reports position and faults to PicoBlaze.

---
 rtl/step_axis_driver.sv | 176 +++++++++++++++++
 tb/tb_step_axis_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/step_axis_driver.sv
// rtl/step_axis_driver.sv - stepper axis driver: step commands to coil phases, position and limits
//
// Purpose:
//   Actuator end of the axis sweep interface. Consumes 2-bit step commands,
//   energizes the stepper coils for HOLD_CYC clocks per step, tracks the
//   absolute position and reports limit flags and sticky faults.
//
// Optional build macro:
//   STEP_AXIS_HALF_STEP_EN - defined: 8-entry half-step table (3-bit phase);
//                            undefined: 4-entry full-step table (2-bit phase).
//
// Ports:
//   clk        in   clock
//   rst        in   reset, asynchronous, active-high
//   cmd        in   2'b10 step up, 2'b01 step down, 2'b00 idle, 2'b11 illegal
//   clr_fault  in   one-cycle pulse, clears fault bits (new events win)
//   coil       out  coil drive {A,B,C,D}, 0000 when not stepping
//   pos        out  current position (never wraps)
//   mn         out  pos == 0 (combinational)
//   mx         out  pos == POS_MAX (combinational)
//   busy       out  high while a step pattern is energized
//   fault      out  sticky: [0] limit violation, [1] illegal cmd, [2] overrun
module step_axis_driver #(
  parameter int POS_W    = 8,
  parameter int POS_MAX  = 200,
  parameter int HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cmd,
  input  logic             clr_fault,
  output logic [3:0]       coil,
  output logic [POS_W-1:0] pos,
  output logic             mn,
  output logic             mx,
  output logic             busy,
  output logic [2:0]       fault
);

`ifdef STEP_AXIS_HALF_STEP_EN
  localparam int PH_W = 3;
`else
  localparam int PH_W = 2;
`endif

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [POS_W-1:0] POS_MAX_V = POS_W'(POS_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(HOLD_CYC - 1);

  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_DN   = 2'b01;
  localparam logic [1:0] CMD_UP   = 2'b10;
  localparam logic [1:0] CMD_BAD  = 2'b11;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_t;

  state_t           state_q;
  logic [POS_W-1:0] pos_q;
  logic [PH_W-1:0]  phase_q;
  logic [PH_W-1:0]  phase_d;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       coil_q;
  logic             busy_q;
  logic [2:0]       fault_q;
  logic [2:0]       fault_d;
  logic [2:0]       fault_set;
  logic             up_ok;
  logic             dn_ok;

  function automatic logic [3:0] pattern(input logic [PH_W-1:0] ph);
    logic [3:0] p;
    p = 4'b0000;
`ifdef STEP_AXIS_HALF_STEP_EN
    case (ph)
      3'd0: p = 4'b1000;
      3'd1: p = 4'b1100;
      3'd2: p = 4'b0100;
      3'd3: p = 4'b0110;
      3'd4: p = 4'b0010;
      3'd5: p = 4'b0011;
      3'd6: p = 4'b0001;
      3'd7: p = 4'b1001;
      default: p = 4'b0000;
    endcase
`else
    case (ph)
      2'd0: p = 4'b1100;
      2'd1: p = 4'b0110;
      2'd2: p = 4'b0011;
      2'd3: p = 4'b1001;
      default: p = 4'b0000;
    endcase
`endif
    return p;
  endfunction

  assign up_ok = (state_q == S_IDLE) && (cmd == CMD_UP) && (pos_q != POS_MAX_V);
  assign dn_ok = (state_q == S_IDLE) && (cmd == CMD_DN) && (pos_q != '0);

  // Phase table length is a power of two, so natural wrap of the index is mod N.
  always_comb begin
    phase_d = phase_q;
    if (up_ok) begin
      phase_d = phase_q + PH_W'(1);
    end else if (dn_ok) begin
      phase_d = phase_q - PH_W'(1);
    end
  end

  // Set-dominant sticky faults: a clear wipes old bits, but a same-cycle event survives.
  always_comb begin
    fault_set = 3'b000;
    if (state_q == S_IDLE) begin
      if ((cmd == CMD_UP && pos_q == POS_MAX_V) || (cmd == CMD_DN && pos_q == '0)) begin
        fault_set[0] = 1'b1;
      end
      if (cmd == CMD_BAD) begin
        fault_set[1] = 1'b1;
      end
    end else if (cmd != CMD_IDLE) begin
      fault_set[2] = 1'b1;
    end
    fault_d = (clr_fault ? 3'b000 : fault_q) | fault_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      coil_q  <= 4'b0000;
      busy_q  <= 1'b0;
      fault_q <= 3'b000;
    end else begin
      fault_q <= fault_d;
      unique case (state_q)
        S_IDLE: begin
          if (up_ok || dn_ok) begin
            pos_q   <= up_ok ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            phase_q <= phase_d;
            cnt_q   <= CNT_LOAD;
            coil_q  <= pattern(phase_d);
            busy_q  <= 1'b1;
            state_q <= S_STEP;
          end
        end
        S_STEP: begin
          if (cnt_q == '0) begin
            coil_q  <= 4'b0000;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          coil_q  <= 4'b0000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign coil  = coil_q;
  assign pos   = pos_q;
  assign busy  = busy_q;
  assign fault = fault_q;
  assign mn    = (pos_q == '0);
  assign mx    = (pos_q == POS_MAX_V);

endmodule

// File: tb/tb_step_axis_driver.sv
// tb/tb_step_axis_driver.sv - self-checking bench for step_axis_driver
module tb_step_axis_driver;

  localparam int POS_W    = 8;
  localparam int POS_MAX  = 5;
  localparam int HOLD_CYC = 4;
`ifdef STEP_AXIS_HALF_STEP_EN
  localparam int NPH = 8;
  localparam logic [3:0] FIRST_UP = 4'b1100;
`else
  localparam int NPH = 4;
  localparam logic [3:0] FIRST_UP = 4'b0110;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       cmd = 2'b00;
  logic             clr_fault = 1'b0;
  logic [3:0]       coil;
  logic [POS_W-1:0] pos;
  logic             mn;
  logic             mx;
  logic             busy;
  logic [2:0]       fault;

  int n_checks = 0;
  int n_fail   = 0;

  step_axis_driver #(
    .POS_W(POS_W),
    .POS_MAX(POS_MAX),
    .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd(cmd),
    .clr_fault(clr_fault),
    .coil(coil),
    .pos(pos),
    .mn(mn),
    .mx(mx),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pat(input int p);
    logic [3:0] r;
    r = 4'b0000;
`ifdef STEP_AXIS_HALF_STEP_EN
    case (p)
      0: r = 4'b1000; 1: r = 4'b1100; 2: r = 4'b0100; 3: r = 4'b0110;
      4: r = 4'b0010; 5: r = 4'b0011; 6: r = 4'b0001; 7: r = 4'b1001;
      default: r = 4'b0000;
    endcase
`else
    case (p)
      0: r = 4'b1100; 1: r = 4'b0110; 2: r = 4'b0011; 3: r = 4'b1001;
      default: r = 4'b0000;
    endcase
`endif
    return r;
  endfunction

  // Model: edge counter plus the edge index at which the current energize window ends.
  // Phase always equals pos mod N because both start at 0 and move together.
  int         cyc      = 0;
  int         busy_end = 0;
  int         m_pos    = 0;
  logic [2:0] m_fault  = 3'b000;

  always @(posedge clk or posedge rst) begin
    logic [2:0] nf;
    logic       was_busy;
    if (rst) begin
      cyc = 0; busy_end = 0; m_pos = 0; m_fault = 3'b000;
    end else begin
      was_busy = (cyc < busy_end);
      cyc++;
      nf = 3'b000;
      if (was_busy) begin
        if (cmd != 2'b00) nf[2] = 1'b1;
      end else begin
        case (cmd)
          2'b10: if (m_pos < POS_MAX) begin m_pos++; busy_end = cyc + HOLD_CYC; end else nf[0] = 1'b1;
          2'b01: if (m_pos > 0) begin m_pos--; busy_end = cyc + HOLD_CYC; end else nf[0] = 1'b1;
          2'b11: nf[1] = 1'b1;
          default: ;
        endcase
      end
      m_fault = (clr_fault ? 3'b000 : m_fault) | nf;
    end
  end

  always @(negedge clk) begin
    logic m_busy;
    if (!rst) begin
      m_busy = (cyc < busy_end);
      chk("cyc_busy",  busy,  m_busy);
      chk("cyc_coil",  coil,  m_busy ? pat(m_pos % NPH) : 4'b0000);
      chk("cyc_pos",   pos,   m_pos);
      chk("cyc_mn",    mn,    m_pos == 0);
      chk("cyc_mx",    mx,    m_pos == POS_MAX);
      chk("cyc_fault", fault, m_fault);
    end
  end

  task automatic issue(input logic [1:0] c, input logic clr);
    @(negedge clk);
    cmd = c; clr_fault = clr;
    @(posedge clk);
    #1;
    cmd = 2'b00; clr_fault = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  logic [3:0] up_seq [5];

  initial begin
    up_seq[0] = 4'b0110; up_seq[1] = 4'b0011; up_seq[2] = 4'b1001;
    up_seq[3] = 4'b1100; up_seq[4] = 4'b0110;

    // 1: reset state
    do_reset();
    chk("rst_coil", coil, 4'b0000);
    chk("rst_pos", pos, 0);
    chk("rst_mn", mn, 1'b1);
    chk("rst_mx", mx, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault, 3'b000);

    // 2: single up step energized for exactly HOLD_CYC clocks
    issue(2'b10, 1'b0);
    chk("up1_pos", pos, 1);
    chk("up1_mn", mn, 1'b0);
    chk("up1_busy", busy, 1'b1);
    chk("up1_coil", coil, FIRST_UP);
    for (int i = 1; i < HOLD_CYC; i++) begin
      wait_edges(1);
      chk("up1_hold_busy", busy, 1'b1);
      chk("up1_hold_coil", coil, FIRST_UP);
    end
    wait_edges(1);
    chk("up1_end_busy", busy, 1'b0);
    chk("up1_end_coil", coil, 4'b0000);

    // 3: back to 0, then down at the lower limit is rejected
    issue(2'b01, 1'b0);
    wait_edges(HOLD_CYC);
    issue(2'b01, 1'b0);
    chk("dn0_pos", pos, 0);
    chk("dn0_busy", busy, 1'b0);
    chk("dn0_coil", coil, 4'b0000);
    chk("dn0_fault", fault, 3'b001);
    issue(2'b00, 1'b1);
    chk("dn0_clr", fault, 3'b000);

`ifndef STEP_AXIS_HALF_STEP_EN
    // 4: walk to POS_MAX through a phase wrap, reject beyond, step back down
    for (int i = 0; i < 5; i++) begin
      issue(2'b10, 1'b0);
      chk("walk_coil", coil, up_seq[i]);
      wait_edges(HOLD_CYC);
    end
    chk("walk_pos", pos, 5);
    chk("walk_mx", mx, 1'b1);
    issue(2'b10, 1'b0);
    chk("over_pos", pos, 5);
    chk("over_fault", fault, 3'b001);
    issue(2'b01, 1'b0);
    chk("back_pos", pos, 4);
    chk("back_coil", coil, 4'b1100);
    chk("back_mx", mx, 1'b0);
    wait_edges(HOLD_CYC);
`endif

    // 5: overrun, illegal command, clear, and clear colliding with a new fault
    do_reset();
    issue(2'b10, 1'b0);
    wait_edges(1);
    issue(2'b10, 1'b0);
    chk("ovr_pos", pos, 1);
    chk("ovr_busy", busy, 1'b1);
    chk("ovr_fault", fault, 3'b100);
    wait_edges(HOLD_CYC);
    issue(2'b11, 1'b0);
    chk("ill_fault", fault, 3'b110);
    issue(2'b00, 1'b1);
    chk("clr_fault", fault, 3'b000);
    issue(2'b11, 1'b1);
    chk("clr_set_fault", fault, 3'b010);

    // 6: async reset in the 2nd STEP clock at pos 3
    issue(2'b10, 1'b0);
    wait_edges(HOLD_CYC);
    issue(2'b10, 1'b0);
    chk("pre_rst_pos", pos, 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_coil", coil, 4'b0000);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_pos", pos, 0);
    chk("arst_fault", fault, 3'b000);
    wait_edges(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
